// File: rtl/sine_pkg.sv
// ---------------------------------------------------------------------------
// sine_pkg
// Shared constants for the sine generator and the sine/cosine demodulator:
// the 64-entry signed sine table (round(127*sin(2*pi*k/64))), table depth,
// quarter-period offset used to read cosine, accumulator width, the demod
// FSM state type and the magnitude helper used when SINE_DEMOD_MAG_EN is set.
// ---------------------------------------------------------------------------
package sine_pkg;

    localparam int LUT_DEPTH = 64;
    localparam int LUT_AW    = 6;
    localparam int QUARTER   = 16;
    localparam int ACC_W     = 24;

    localparam logic signed [7:0] SIN_TABLE [LUT_DEPTH] = '{
          8'sd0,    8'sd12,   8'sd25,   8'sd37,   8'sd49,   8'sd60,   8'sd71,   8'sd81,
          8'sd90,   8'sd98,   8'sd106,  8'sd112,  8'sd117,  8'sd122,  8'sd125,  8'sd126,
          8'sd127,  8'sd126,  8'sd125,  8'sd122,  8'sd117,  8'sd112,  8'sd106,  8'sd98,
          8'sd90,   8'sd81,   8'sd71,   8'sd60,   8'sd49,   8'sd37,   8'sd25,   8'sd12,
          8'sd0,   -8'sd12,  -8'sd25,  -8'sd37,  -8'sd49,  -8'sd60,  -8'sd71,  -8'sd81,
         -8'sd90,  -8'sd98,  -8'sd106, -8'sd112, -8'sd117, -8'sd122, -8'sd125, -8'sd126,
         -8'sd127, -8'sd126, -8'sd125, -8'sd122, -8'sd117, -8'sd112, -8'sd106, -8'sd98,
         -8'sd90,  -8'sd81,  -8'sd71,  -8'sd60,  -8'sd49,  -8'sd37,  -8'sd25,  -8'sd12
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } demod_state_t;

    // min(255, (|I| + |Q|) >> shift); accumulators never reach -2^(ACC_W-1),
    // so negation cannot overflow.
    function automatic logic [7:0] mag_sat(input logic signed [ACC_W-1:0] i_acc,
                                           input logic signed [ACC_W-1:0] q_acc,
                                           input int unsigned              shift);
        logic [ACC_W-1:0] i_abs;
        logic [ACC_W-1:0] q_abs;
        logic [ACC_W:0]   sum;
        logic [ACC_W:0]   scaled;
        i_abs  = i_acc[ACC_W-1] ? ACC_W'(-i_acc) : ACC_W'(i_acc);
        q_abs  = q_acc[ACC_W-1] ? ACC_W'(-q_acc) : ACC_W'(q_acc);
        sum    = {1'b0, i_abs} + {1'b0, q_abs};
        scaled = sum >> shift;
        if (|scaled[ACC_W:8]) begin
            mag_sat = 8'd255;
        end else begin
            mag_sat = scaled[7:0];
        end
    endfunction

endpackage

// File: rtl/sine_lut.sv
// ---------------------------------------------------------------------------
// sine_lut
// Dual-read combinational lookup into the shared sine table.
// Ports:
//   sin_idx / cos_idx : 6-bit table indices (caller adds the quarter offset
//                       for the cosine read)
//   sin_val / cos_val : signed 8-bit table entries
// ---------------------------------------------------------------------------
module sine_lut
    import sine_pkg::*;
(
    input  logic        [LUT_AW-1:0] sin_idx,
    input  logic        [LUT_AW-1:0] cos_idx,
    output logic signed [7:0]        sin_val,
    output logic signed [7:0]        cos_val
);

    assign sin_val = SIN_TABLE[sin_idx];
    assign cos_val = SIN_TABLE[cos_idx];

endmodule

// File: rtl/sine_demod.sv
// ---------------------------------------------------------------------------
// sine_demod
// Quadrature correlator: each accepted offset-binary sample is multiplied by
// the sine and cosine reference (stage 1), summed into Q and I accumulators
// (stage 2) and, after SYM_LEN samples, the signs of Q/I (and optionally the
// magnitude) are registered with a one-cycle sym_valid pulse (stage 3).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   sinein[7:0]       : offset-binary sample (128 = zero)
//   sample_valid      : sinein accepted this cycle
//   sym_start         : first sample of a symbol (restarts phase and count)
//   dataeve, dataodd  : sign of Q (sine) / I (cosine) correlation
//   sym_valid         : one-cycle pulse when outputs update
//   magout[7:0]       : magnitude estimate; present only when the macro
//                       SINE_DEMOD_MAG_EN is defined, otherwise tied to 0
// ---------------------------------------------------------------------------
module sine_demod
    import sine_pkg::*;
#(
    parameter int SYM_LEN    = 64,
    parameter int PHASE_STEP = 1,
    parameter int MAG_SHIFT  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sinein,
    input  logic       sample_valid,
    input  logic       sym_start,
    output logic       dataeve,
    output logic       dataodd,
    output logic       sym_valid,
    output logic [7:0] magout
);

    localparam int                 CNT_W    = $clog2(SYM_LEN);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SYM_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [LUT_AW-1:0]  K_STEP   = LUT_AW'(PHASE_STEP % LUT_DEPTH);
    localparam logic [LUT_AW-1:0]  K_QUART  = LUT_AW'(QUARTER);

    demod_state_t              state_q, state_d;
    logic [LUT_AW-1:0]         k_q, k_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [15:0]        psin_q, psin_d;
    logic signed [15:0]        pcos_q, pcos_d;
    logic                      p_vld_q, p_vld_d;
    logic                      p_first_q, p_first_d;
    logic                      p_last_q, p_last_d;
    logic signed [ACC_W-1:0]   qacc_q, qacc_d;
    logic signed [ACC_W-1:0]   iacc_q, iacc_d;
    logic                      done_q, done_d;
    logic                      dataeve_q, dataeve_d;
    logic                      dataodd_q, dataodd_d;
    logic                      sym_valid_q, sym_valid_d;

    logic                      accept_s;
    logic [LUT_AW-1:0]         k_idx_s;
    logic [CNT_W-1:0]          cnt_idx_s;
    logic signed [8:0]         d_s;
    logic signed [7:0]         sin_val_s;
    logic signed [7:0]         cos_val_s;
    logic signed [16:0]        mul_sin_s;
    logic signed [16:0]        mul_cos_s;
    logic signed [ACC_W-1:0]   psin_ext_s;
    logic signed [ACC_W-1:0]   pcos_ext_s;

    // A sample with sym_start uses phase/count 0 even though k/cnt still hold old values.
    assign k_idx_s   = sym_start ? {LUT_AW{1'b0}} : k_q;
    assign cnt_idx_s = sym_start ? {CNT_W{1'b0}}  : cnt_q;

    sine_lut u_lut (
        .sin_idx (k_idx_s),
        .cos_idx (k_idx_s + K_QUART),
        .sin_val (sin_val_s),
        .cos_val (cos_val_s)
    );

    // Next-state logic for phase, counter, product stage, accumulators and outputs.
    always_comb begin
        accept_s   = sample_valid & ((state_q == ST_RUN) | sym_start);
        d_s        = $signed({1'b0, sinein}) - 9'sd128;
        mul_sin_s  = d_s * sin_val_s;
        mul_cos_s  = d_s * cos_val_s;
        psin_ext_s = {{(ACC_W-16){psin_q[15]}}, psin_q};
        pcos_ext_s = {{(ACC_W-16){pcos_q[15]}}, pcos_q};

        if (sym_start) begin
            state_d = ST_RUN;
        end else begin
            state_d = state_q;
        end

        // Phase and count advance only on accepted samples; sym_start alone clears them.
        if (accept_s) begin
            k_d   = k_idx_s + K_STEP;
            cnt_d = cnt_idx_s + CNT_ONE;
        end else if (sym_start) begin
            k_d   = {LUT_AW{1'b0}};
            cnt_d = {CNT_W{1'b0}};
        end else begin
            k_d   = k_q;
            cnt_d = cnt_q;
        end

        // Stage 1: products travel with first/last markers so stage 2 can
        // restart the sum and flag symbol completion.
        p_vld_d = accept_s;
        if (accept_s) begin
            psin_d    = mul_sin_s[15:0];
            pcos_d    = mul_cos_s[15:0];
            p_first_d = (cnt_idx_s == {CNT_W{1'b0}});
            p_last_d  = (cnt_idx_s == LAST_CNT);
        end else begin
            psin_d    = psin_q;
            pcos_d    = pcos_q;
            p_first_d = p_first_q;
            p_last_d  = p_last_q;
        end

        // Stage 2: sample 0 overwrites, which also discards any abandoned partial sum.
        done_d = p_vld_q & p_last_q;
        if (p_vld_q) begin
            qacc_d = p_first_q ? psin_ext_s : (qacc_q + psin_ext_s);
            iacc_d = p_first_q ? pcos_ext_s : (iacc_q + pcos_ext_s);
        end else begin
            qacc_d = qacc_q;
            iacc_d = iacc_q;
        end

        // Stage 3: decisions sampled from the finished sums.
        sym_valid_d = done_q;
        if (done_q) begin
            dataeve_d = ~qacc_q[ACC_W-1] & (|qacc_q);
            dataodd_d = ~iacc_q[ACC_W-1] & (|iacc_q);
        end else begin
            dataeve_d = dataeve_q;
            dataodd_d = dataodd_q;
        end
    end

    // State registers for FSM, datapath pipeline and decision outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= {LUT_AW{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            psin_q      <= 16'sd0;
            pcos_q      <= 16'sd0;
            p_vld_q     <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            qacc_q      <= {ACC_W{1'b0}};
            iacc_q      <= {ACC_W{1'b0}};
            done_q      <= 1'b0;
            dataeve_q   <= 1'b0;
            dataodd_q   <= 1'b0;
            sym_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            psin_q      <= psin_d;
            pcos_q      <= pcos_d;
            p_vld_q     <= p_vld_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            qacc_q      <= qacc_d;
            iacc_q      <= iacc_d;
            done_q      <= done_d;
            dataeve_q   <= dataeve_d;
            dataodd_q   <= dataodd_d;
            sym_valid_q <= sym_valid_d;
        end
    end

    assign dataeve   = dataeve_q;
    assign dataodd   = dataodd_q;
    assign sym_valid = sym_valid_q;

`ifdef SINE_DEMOD_MAG_EN
    logic [7:0] magout_q, magout_d;

    // Magnitude updates together with the decision bits.
    always_comb begin
        if (done_q) begin
            magout_d = mag_sat(iacc_q, qacc_q, MAG_SHIFT);
        end else begin
            magout_d = magout_q;
        end
    end

    // Magnitude output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            magout_q <= 8'd0;
        end else begin
            magout_q <= magout_d;
        end
    end

    assign magout = magout_q;
`else
    assign magout = 8'd0;
`endif

endmodule

// File: doc/sine_demod.md
SINE_DEMOD -- requirements
Module: sine_demod

Interface
REQ-001 SHALL have parameter SYM_LEN, default 64, meaning samples per symbol (power of two, 16..256).
REQ-002 SHALL have parameter PHASE_STEP, default 1, meaning the LUT index increment per accepted sample (modulo 64).
REQ-003 SHALL have parameter MAG_SHIFT, default 12, meaning the right shift applied to the magnitude estimate.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sinein  input  8  offset-binary sample (128 = zero), the sine/cos generator output format.
REQ-007 SHALL have port sample_valid  input  1  sinein is accepted this cycle.
REQ-008 SHALL have port sym_start  input  1  pulse marking the first sample of a symbol.
REQ-009 SHALL have port dataeve  output  1  recovered even bit (sine-correlation sign).
REQ-010 SHALL have port dataodd  output  1  recovered odd bit (cosine-correlation sign).
REQ-011 SHALL have port sym_valid  output  1  one-cycle pulse; dataeve/dataodd/magout updated.
REQ-012 SHALL have port magout  output  8  symbol magnitude estimate.

Function
REQ-013 SHALL convert each accepted sample to signed 9-bit d = sinein - 128.
REQ-014 SHALL hold a 64-entry signed 8-bit table sin_lut[k] = round(127*sin(2*pi*k/64)); cosine read at index (k+16) mod 64.
REQ-015 SHALL, per accepted sample, form 16-bit signed products d*sin_lut[k] and d*cos_lut[k] (stage 1, registered), then add into 24-bit signed accumulators Q and I (stage 2); no overflow possible within SYM_LEN range.
REQ-016 SHALL advance k by PHASE_STEP and a sample counter by 1 only on accepted samples; sample_valid low freezes all pipeline state.
REQ-017 SHALL implement FSM IDLE -> RUN on sym_start; RUN stays RUN; only reset returns to IDLE; samples in IDLE without sym_start are ignored.
REQ-018 SHALL, on sym_start (IDLE or RUN), set k=0 and counter=0, discard any partial symbol without pulsing sym_valid, and treat a simultaneous valid sample as sample 0.
REQ-019 SHALL, when sample SYM_LEN-1 is accepted in cycle N, present dataeve = (Q > 0), dataodd = (I > 0), and magout, with sym_valid high for exactly cycle N+3.
REQ-020 SHALL restart accumulation at zero with the sample following the last one, so back-to-back samples every cycle lose no data.
REQ-021 SHALL hold dataeve/dataodd/magout stable between sym_valid pulses.

Reset
REQ-022 SHALL on reset asynchronously clear FSM to IDLE, k, counter, I, Q, pipeline registers, and set dataeve=0, dataodd=0, sym_valid=0, magout=0.
REQ-023 SHALL, on reset mid-symbol, produce no sym_valid for that symbol and require a new sym_start.

Configuration
REQ-024 SHALL with SINE_DEMOD_MAG_EN defined drive magout = min(255, (|I|+|Q|) >> MAG_SHIFT), updated with sym_valid.
REQ-025 SHALL without SINE_DEMOD_MAG_EN keep the magout port but tie it to 0 and omit the magnitude logic.

Structure
REQ-026 SHALL place the 64-entry sine table, LUT depth (64), quarter offset (16), and the accumulator width (24) in shared package sine_pkg, reused with the generator.
REQ-027 SHALL implement the table lookup as sub-module sine_lut (dual read: sine and cosine index).

Verification
REQ-028 SHALL cover: sym_start, then 64 samples of 128 -> sym_valid once, dataeve=0, dataodd=0, magout=0.
REQ-029 SHALL cover: 64 samples of 128+sin_lut[k] -> dataeve=1, dataodd=0, magout=126 (+-2, MAG_SHIFT=12).
REQ-030 SHALL cover: 128+cos_lut[k] then 128-sin_lut[k]-cos_lut[k] (saturated to 0..255) back-to-back every cycle -> two sym_valid 64 cycles apart, bits 0/1 then 0/0.
REQ-031 SHALL cover: sym_start re-asserted at sample 30 -> no sym_valid for partial, next pulse 3 cycles after 64th sample from restart.
REQ-032 SHALL cover: reset at sample 40, sample_valid toggling 50% -> outputs zero immediately, no sym_valid until new sym_start plus 64 accepted samples.
